// File: rtl/matmul_engine.sv
// matmul_engine: C = A x B (or C += A x B) for run-time m x n x p up to MAX_DIM.
// Each MAC cycle updates LANES rows of one output column in parallel.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; cfg latched on accept
// S_CHECK | validate dimensions, reset loop counters
// S_CLEAR | zero every C element (skipped when accumulating)
// S_MAC   | one k step for LANES rows of column j
// S_DONE  | one-cycle completion pulse
module matmul_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_DIM = 8,
    parameter int LANES   = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(MAX_DIM+1)-1:0]        cfg_m,
    input  logic [$clog2(MAX_DIM+1)-1:0]        cfg_n,
    input  logic [$clog2(MAX_DIM+1)-1:0]        cfg_p,
    input  logic                                cfg_signed,
    input  logic                                cfg_acc,
    input  logic                                cfg_sat,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   mat_a_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   mat_b_i,
    output logic [MAX_DIM*MAX_DIM*ACC_W-1:0]    mat_c_o,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                ovf
);
    localparam int DIM_W  = $clog2(MAX_DIM+1);
    localparam int NUM_EL = MAX_DIM*MAX_DIM;
    localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam int A_BW   = $clog2(NUM_EL*DATA_W);
    localparam logic [DIM_W-1:0] MAX_D   = DIM_W'(MAX_DIM);
    localparam logic [DIM_W:0]   LANES_D = (DIM_W+1)'(LANES);
    localparam logic [ACC_W-1:0] SMAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN    = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX    = {ACC_W{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CLEAR, S_MAC, S_DONE} state_t;
    state_t state, state_nx;

    logic [DIM_W-1:0] m_q, n_q, p_q, i_q, j_q, k_q;
    logic             signed_q, acc_q, sat_q, err_q, ovf_q;
    logic [ACC_W-1:0] c_q [NUM_EL];

    logic             dim_bad, last_k, last_j, last_i;
    logic [LANES-1:0] lane_en, lane_ovf;
    logic [IDX_W-1:0] lane_ci  [LANES];
    logic [DATA_W-1:0] a_el    [LANES];
    logic [DATA_W-1:0] b_el    [LANES];
    logic [2*DATA_W-1:0] prod  [LANES];
    logic [ACC_W:0]   prod_x   [LANES];
    logic [ACC_W:0]   c_x      [LANES];
    logic [ACC_W:0]   sum      [LANES];
    logic [ACC_W-1:0] lane_val [LANES];

    assign dim_bad = (m_q == '0) || (m_q > MAX_D) || (n_q == '0) || (n_q > MAX_D) ||
                     (p_q == '0) || (p_q > MAX_D);
    assign last_k  = (k_q == n_q - DIM_W'(1));
    assign last_j  = (j_q == p_q - DIM_W'(1));
    assign last_i  = (({1'b0, i_q} + LANES_D) >= {1'b0, m_q});

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q;
    assign ovf  = ovf_q;

    for (genvar e = 0; e < NUM_EL; e++) begin : g_c_out
        assign mat_c_o[e*ACC_W +: ACC_W] = c_q[e];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CHECK;
            S_CHECK: state_nx = dim_bad ? S_DONE : (acc_q ? S_MAC : S_CLEAR);
            S_CLEAR: state_nx = S_MAC;
            S_MAC:   if (last_k && last_j && last_i) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-lane multiply-accumulate with overflow detection and optional clamp.
    always_comb begin
        for (int g = 0; g < LANES; g++) begin
            lane_en[g]  = 1'b0;
            lane_ci[g]  = '0;
            a_el[g]     = '0;
            b_el[g]     = '0;
            prod[g]     = '0;
            prod_x[g]   = '0;
            c_x[g]      = '0;
            sum[g]      = '0;
            lane_ovf[g] = 1'b0;
            lane_val[g] = '0;
            if ((state == S_MAC) && ((int'(i_q) + g) < int'(m_q))) begin
                lane_en[g] = 1'b1;
                lane_ci[g] = IDX_W'((int'(i_q) + g) * MAX_DIM + int'(j_q));
                a_el[g]    = mat_a_i[A_BW'(((int'(i_q) + g) * MAX_DIM + int'(k_q)) * DATA_W) +: DATA_W];
                b_el[g]    = mat_b_i[A_BW'((int'(k_q) * MAX_DIM + int'(j_q)) * DATA_W) +: DATA_W];
            end
            if (signed_q) begin
                prod[g]   = {{DATA_W{a_el[g][DATA_W-1]}}, a_el[g]} *
                            {{DATA_W{b_el[g][DATA_W-1]}}, b_el[g]};
                prod_x[g] = {{(ACC_W+1-2*DATA_W){prod[g][2*DATA_W-1]}}, prod[g]};
                c_x[g]    = {c_q[lane_ci[g]][ACC_W-1], c_q[lane_ci[g]]};
            end else begin
                prod[g]   = {{DATA_W{1'b0}}, a_el[g]} * {{DATA_W{1'b0}}, b_el[g]};
                prod_x[g] = {{(ACC_W+1-2*DATA_W){1'b0}}, prod[g]};
                c_x[g]    = {1'b0, c_q[lane_ci[g]]};
            end
            sum[g]      = c_x[g] + prod_x[g];
            lane_ovf[g] = signed_q ? (sum[g][ACC_W] ^ sum[g][ACC_W-1]) : sum[g][ACC_W];
            if (lane_ovf[g] && sat_q)
                lane_val[g] = signed_q ? (sum[g][ACC_W] ? SMIN : SMAX) : UMAX;
            else
                lane_val[g] = sum[g][ACC_W-1:0];
        end
    end

    // Config capture, loop counters, status flags and C storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0; n_q <= '0; p_q <= '0;
            i_q <= '0; j_q <= '0; k_q <= '0;
            signed_q <= 1'b0; acc_q <= 1'b0; sat_q <= 1'b0;
            err_q <= 1'b0; ovf_q <= 1'b0;
            for (int e = 0; e < NUM_EL; e++) c_q[e] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    m_q <= cfg_m; n_q <= cfg_n; p_q <= cfg_p;
                    signed_q <= cfg_signed; acc_q <= cfg_acc; sat_q <= cfg_sat;
                    err_q <= 1'b0; ovf_q <= 1'b0;
                end
                S_CHECK: begin
                    i_q <= '0; j_q <= '0; k_q <= '0;
                    if (dim_bad) err_q <= 1'b1;
                end
                S_CLEAR: for (int e = 0; e < NUM_EL; e++) c_q[e] <= '0;
                S_MAC: begin
                    for (int g = 0; g < LANES; g++)
                        if (lane_en[g]) c_q[lane_ci[g]] <= lane_val[g];
                    if (|(lane_en & lane_ovf)) ovf_q <= 1'b1;
                    if (!last_k) begin
                        k_q <= k_q + DIM_W'(1);
                    end else begin
                        k_q <= '0;
                        if (!last_j) begin
                            j_q <= j_q + DIM_W'(1);
                        end else begin
                            j_q <= '0;
                            i_q <= i_q + DIM_W'(LANES);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
